// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit.
package lsu_pkg;

  localparam int unsigned LSU_DATA_W = 16;
  localparam int unsigned LSU_ADDR_W = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;

  typedef struct packed {
    logic                  we;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
    logic                  err;
  } lsu_req_t;

endpackage

// File: rtl/load_store_unit.sv
// Data-memory initiator: one request at a time through IDLE -> ACCESS -> RESP,
// with back-to-back acceptance when the response is consumed.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned DATA_W    = LSU_DATA_W,
  parameter int unsigned ADDR_W    = LSU_ADDR_W,
  parameter int unsigned MEM_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_was_store,
  output logic              mem_wr_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_Addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  lsu_state_t        state_q, state_d;
  lsu_req_t          req_q, req_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_was_store_q, rsp_was_store_d;
  lsu_req_t          req_in;

  // Incoming request with its range check, used wherever a transfer happens.
  always_comb begin
    req_in.we    = req_we;
    req_in.addr  = LSU_ADDR_W'(req_addr);
    req_in.wdata = LSU_DATA_W'(req_wdata);
    req_in.err   = (req_addr >= ADDR_W'(MEM_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      req_q           <= '0;
      rsp_rdata_q     <= '0;
      rsp_err_q       <= 1'b0;
      rsp_was_store_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_err_q       <= rsp_err_d;
      rsp_was_store_q <= rsp_was_store_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_err_d       = rsp_err_q;
    rsp_was_store_d = rsp_was_store_q;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    mem_wr_en       = 1'b0;
    mem_read_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          req_d   = req_in;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_wr_en       = req_q.we && !req_q.err;
        mem_read_en     = !req_q.we && !req_q.err;
        rsp_rdata_d     = mem_read_en ? mem_rd_data : '0;
        rsp_err_d       = req_q.err;
        rsp_was_store_d = req_q.we;
        state_d         = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready) begin
          if (req_valid) begin
            req_d   = req_in;
            state_d = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_was_store = rsp_was_store_q;
  assign mem_Addr      = ADDR_W'(req_q.addr);
  assign mem_wr_data   = DATA_W'(req_q.wdata);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_was_store;
  logic [15:0] rsp_rdata;
  logic        mem_wr_en, mem_read_en, busy;
  logic [15:0] mem_Addr, mem_wr_data, mem_rd_data;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int cyc    = 0;

  logic [15:0] mem [8];

  load_store_unit #(.DATA_W(16), .ADDR_W(16), .MEM_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_was_store(rsp_was_store),
    .mem_wr_en(mem_wr_en), .mem_read_en(mem_read_en), .mem_Addr(mem_Addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb mem_rd_data = (mem_Addr < 16'd8) ? mem[mem_Addr[2:0]] : 16'h0000;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_Addr < 16'd8) mem[mem_Addr[2:0]] <= mem_wr_data;
    end
    if (mem_read_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One full transaction with rsp_ready held high.
  task automatic do_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic [15:0] exp_rd, input logic exp_err, input string nm);
    int wc0, rc0;
    @(negedge clk);
    chk({nm, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
    wc0 = wr_cnt; rc0 = rd_cnt;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk({nm, " mem_Addr"}, 32'(mem_Addr), 32'(addr));
    chk({nm, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
    if (we) chk({nm, " mem_wr_data"}, 32'(mem_wr_data), 32'(wdata));
    @(negedge clk);
    chk({nm, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, " rsp_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    chk({nm, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
    chk({nm, " rsp_was_store"}, 32'(rsp_was_store), 32'(we));
    @(posedge clk); #1;
    chk({nm, " wr pulses"}, 32'(wr_cnt - wc0), 32'(we && !exp_err));
    chk({nm, " rd pulses"}, 32'(rd_cnt - rc0), 32'(!we && !exp_err));
    chk({nm, " busy after"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
    string       nm;
  } vec_t;

  vec_t vecs [8];

  // Back-to-back response monitor
  logic        b2b_mon = 1'b0;
  int          rsp_idx = 0;
  logic [15:0] b2b_addr [4];
  logic [15:0] b2b_exp  [4];
  int          acc_cyc  [4];

  always @(negedge clk) begin
    if (b2b_mon && rsp_valid) begin
      if (rsp_idx < 4) chk($sformatf("b2b rsp%0d data", rsp_idx), 32'(rsp_rdata), 32'(b2b_exp[rsp_idx]));
      else chk("b2b extra rsp", 32'(rsp_idx), 32'd3);
      rsp_idx++;
    end
  end

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 16'h1000 + 16'(i);
    mem[2] = 16'h1234;
    mem[5] = 16'h5555;

    vecs[0] = '{1'b1, 16'd3,    16'hBEEF, 16'h0000, 1'b0, "store3"};
    vecs[1] = '{1'b0, 16'd3,    16'h0000, 16'hBEEF, 1'b0, "load3"};
    vecs[2] = '{1'b0, 16'd7,    16'h0000, 16'h1007, 1'b0, "load7"};
    vecs[3] = '{1'b0, 16'd8,    16'h0000, 16'h0000, 1'b1, "load8"};
    vecs[4] = '{1'b1, 16'hFFFF, 16'h5A5A, 16'h0000, 1'b1, "storeFFFF"};
    vecs[5] = '{1'b0, 16'd0,    16'h0000, 16'h1000, 1'b0, "load0"};
    vecs[6] = '{1'b1, 16'd7,    16'h7777, 16'h0000, 1'b0, "store7"};
    vecs[7] = '{1'b0, 16'd7,    16'h0000, 16'h7777, 1'b0, "load7b"};

    b2b_addr[0] = 16'd0; b2b_exp[0] = 16'h1000;
    b2b_addr[1] = 16'd2; b2b_exp[1] = 16'h1234;
    b2b_addr[2] = 16'd3; b2b_exp[2] = 16'hBEEF;
    b2b_addr[3] = 16'd5; b2b_exp[3] = 16'h5555;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
    #3;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("reset mem_Addr", 32'(mem_Addr), 32'd0);
    chk("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
    #9 rst_n = 1'b1;
    #1 chk("post-reset req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++)
      do_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].nm);

    // Backpressure: hold the load-2 response for 5 cycles with a pending load 5.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'd2; rsp_ready = 1'b0;
    @(posedge clk); #1 req_addr = 16'd5;
    @(negedge clk);
    chk("bp req_ready in access", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d rsp_rdata", i), 32'(rsp_rdata), 32'h1234);
      chk($sformatf("bp%0d req_ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d mem_read_en", i), 32'(mem_read_en), 32'd0);
    end
    rsp_ready = 1'b1;
    #1 chk("bp req_ready released", 32'(req_ready), 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("bp pending read_en", 32'(mem_read_en), 32'd1);
    chk("bp pending addr", 32'(mem_Addr), 32'd5);
    chk("bp pending rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    chk("bp pending rsp_valid2", 32'(rsp_valid), 32'd1);
    chk("bp pending rdata", 32'(rsp_rdata), 32'h5555);

    // Back-to-back: 4 loads, one accept every 2 cycles.
    @(posedge clk); #1;
    rsp_idx = 0;
    b2b_mon = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = b2b_addr[0]; rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int w;
      w = 0;
      while (!req_ready && w < 10) begin
        @(negedge clk);
        w++;
      end
      if (w >= 10) chk($sformatf("b2b accept%0d timeout", k), 32'(w), 32'd0);
      acc_cyc[k] = cyc;
      @(posedge clk); #1;
      if (k < 3) req_addr = b2b_addr[k+1];
      else req_valid = 1'b0;
      @(negedge clk);
    end
    for (int k = 1; k < 4; k++)
      chk($sformatf("b2b spacing%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd2);
    begin
      int w;
      w = 0;
      while (rsp_idx < 4 && w < 10) begin
        @(negedge clk);
        w++;
      end
    end
    @(negedge clk);
    b2b_mon = 1'b0;
    chk("b2b rsp count", 32'(rsp_idx), 32'd4);

    // Async reset in the ACCESS of a store to addr 5.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'd5; req_wdata = 16'hAAAA;
    @(posedge clk); #1 req_valid = 1'b0;
    #2 chk("rst store wr_en before", 32'(mem_wr_en), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst mem_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst mem_Addr", 32'(mem_Addr), 32'd0);
    chk("rst mem_wr_data", 32'(mem_wr_data), 32'd0);
    chk("rst rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    @(posedge clk); #1;
    chk("rst mem5 untouched", 32'(mem[5]), 32'h5555);
    @(negedge clk) rst_n = 1'b1;
    do_txn(1'b0, 16'd5, 16'h0000, 16'h5555, 1'b0, "load5 after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
